// File: rtl/mult_share_arbiter_if.sv
// Request, response and shared-multiplier signals of the two-requester multiplier arbiter.
// master = arbiter side, slave = requesters plus the shared multiplier.
interface mult_share_arbiter_if;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_a0;
    logic [3:0] req_b0;
    logic [3:0] req_a1;
    logic [3:0] req_b1;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [7:0] rsp_product;
    logic       rsp_err;
    logic       mul_start;
    logic [3:0] mul_multiplier;
    logic [3:0] mul_multiplicand;
    logic       mul_done;
    logic [7:0] mul_product;

    modport master (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready, mul_done, mul_product,
        output req_ready, rsp_valid, rsp_product, rsp_err, mul_start, mul_multiplier, mul_multiplicand
    );

    modport slave (
        output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready, mul_done, mul_product,
        input  req_ready, rsp_valid, rsp_product, rsp_err, mul_start, mul_multiplier, mul_multiplicand
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Two requesters share one sequential 4x4 multiplier; round-robin, or fixed priority with MULT_ARB_FIXED_PRIO_EN.
// Latency: accept at N, mul_start at N+1, result valid the cycle after mul_done (or after TIMEOUT WAIT cycles).
// Backpressure: result held until the owner's rsp_ready; req_ready stays low while busy.
module mult_share_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_share_arbiter_if.master bus,
    output logic                 busy,
    output logic                 grant
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       armed;
    logic       win;
    logic [1:0] ready;
    logic       accept;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       start_q;
    logic [1:0] rsp_vld_q;
    logic [7:0] rsp_prod_q;
    logic       rsp_err_q;

`ifdef MULT_ARB_FIXED_PRIO_EN
    always_comb win = ~bus.req_valid[0];
`else
    logic last;

    always_comb begin
        if (bus.req_valid == 2'b11) win = ~last;
        else                        win = ~bus.req_valid[0];
    end
`endif

    // armed keeps the first cycle after reset release free of accepts
    always_comb begin
        ready = 2'b00;
        if (state == IDLE && armed && bus.req_valid != 2'b00)
            ready = win ? 2'b10 : 2'b01;
    end

    assign accept               = |(bus.req_valid & ready);
    assign bus.req_ready        = ready;
    assign bus.mul_start        = start_q;
    assign bus.mul_multiplier   = a_q;
    assign bus.mul_multiplicand = b_q;
    assign bus.rsp_valid        = rsp_vld_q;
    assign bus.rsp_product      = rsp_prod_q;
    assign bus.rsp_err          = rsp_err_q;
    assign busy                 = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            grant      <= 1'b0;
            cnt        <= 8'd0;
            a_q        <= 4'd0;
            b_q        <= 4'd0;
            start_q    <= 1'b0;
            rsp_vld_q  <= 2'b00;
            rsp_prod_q <= 8'd0;
            rsp_err_q  <= 1'b0;
`ifndef MULT_ARB_FIXED_PRIO_EN
            last       <= 1'b1;
`endif
        end else begin
            armed   <= 1'b1;
            start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant   <= win;
                        a_q     <= win ? bus.req_a1 : bus.req_a0;
                        b_q     <= win ? bus.req_b1 : bus.req_b0;
                        start_q <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= 8'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    // a completion on the final wait cycle still wins over the abort
                    if (bus.mul_done) begin
                        rsp_prod_q <= bus.mul_product;
                        rsp_err_q  <= 1'b0;
                        rsp_vld_q  <= grant ? 2'b10 : 2'b01;
                        state      <= RESP;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        rsp_prod_q <= 8'd0;
                        rsp_err_q  <= 1'b1;
                        rsp_vld_q  <= grant ? 2'b10 : 2'b01;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[grant]) begin
                        rsp_vld_q <= 2'b00;
`ifndef MULT_ARB_FIXED_PRIO_EN
                        last      <= grant;
`endif
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: stimulus queues expected results, a monitor checks each response.
module tb_mult_share_arbiter;
    localparam int TIMEOUT = 16;

    typedef struct {
        bit         owner;
        logic [7:0] prod;
        bit         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic grant;

    mult_share_arbiter_if bus ();

    mult_share_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .grant (grant)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    exp_t       exp_q[$];
    exp_t       e;
    int         cur_lat = 1;
    int         cur_bp = 0;
    logic [3:0] exp_a = 4'd0;
    logic [3:0] exp_b = 4'd0;
    int         acc_cyc = 0;
    int         exp_rsp_cyc = 0;
    bit         model_last = 1'b1;
    bit         late_pulse = 1'b0;
    int         nstart = 0;
    bit         in_rsp = 1'b0;
    logic [7:0] hold_prod;
    logic [1:0] hold_vld;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_product"}, bus.rsp_product, 0);
        chk({tag, "_rsp_err"}, bus.rsp_err, 0);
        chk({tag, "_mul_start"}, bus.mul_start, 0);
        chk({tag, "_mul_multiplier"}, bus.mul_multiplier, 0);
        chk({tag, "_mul_multiplicand"}, bus.mul_multiplicand, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant"}, grant, 0);
    endtask

    // Monitor: response timing, stability under backpressure, and scoreboard comparison at each handshake.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.mul_start === 1'b1) nstart++;
            if (busy === 1'b1) chk("req_ready_while_busy", bus.req_ready, 0);
            if (bus.rsp_valid !== 2'b00) begin
                if (!in_rsp) begin
                    in_rsp    = 1'b1;
                    hold_prod = bus.rsp_product;
                    hold_vld  = bus.rsp_valid;
                    chk("rsp_latency", cyc, exp_rsp_cyc);
                end else begin
                    chk("rsp_product_hold", bus.rsp_product, hold_prod);
                    chk("rsp_valid_hold", bus.rsp_valid, hold_vld);
                end
                if ((bus.rsp_ready & bus.rsp_valid) != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", bus.rsp_valid, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_valid_owner", bus.rsp_valid, e.owner ? 2'b10 : 2'b01);
                        chk("grant", grant, e.owner);
                        chk("rsp_product", bus.rsp_product, e.prod);
                        chk("rsp_err", bus.rsp_err, e.err);
                        chk("mul_start_pulses", nstart, 1);
                        model_last = e.owner;
                    end
                    in_rsp = 1'b0;
                    nstart = 0;
                end
            end
        end
    end

    // Shared multiplier model: done pulse cur_lat cycles after mul_start; cur_lat==0 never completes.
    initial begin
        int         cnt;
        logic [7:0] prod;
        cnt = 0;
        prod = 8'd0;
        bus.mul_done = 1'b0;
        bus.mul_product = 8'd0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && cnt > 0)
                chk("operand_hold", {bus.mul_multiplier, bus.mul_multiplicand}, {exp_a, exp_b});
            if (rst === 1'b1 && bus.mul_start === 1'b1) begin
                chk("start_latency", cyc, acc_cyc + 1);
                chk("mul_multiplier", bus.mul_multiplier, exp_a);
                chk("mul_multiplicand", bus.mul_multiplicand, exp_b);
                prod = {4'd0, bus.mul_multiplier} * {4'd0, bus.mul_multiplicand};
                cnt = cur_lat;
                exp_rsp_cyc = cyc + ((cur_lat == 0) ? TIMEOUT : cur_lat) + 1;
            end
            @(posedge clk);
            #1;
            bus.mul_done = 1'b0;
            bus.mul_product = 8'($urandom);
            if (rst !== 1'b1) cnt = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.mul_done = 1'b1;
                    bus.mul_product = prod;
                end
            end
            if (late_pulse) begin
                bus.mul_done = 1'b1;
                bus.mul_product = 8'hAA;
                late_pulse = 1'b0;
            end
        end
    end

    // Response consumer: cur_bp cycles with only the non-owner ready, then the owner consumes.
    initial begin
        int bp_cnt;
        bp_cnt = 0;
        bus.rsp_ready = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid != 2'b00) begin
                if (bp_cnt < cur_bp) begin
                    bus.rsp_ready = ~bus.rsp_valid;
                    bp_cnt++;
                end else begin
                    bus.rsp_ready = bus.rsp_valid | 2'($urandom);
                end
            end else begin
                bus.rsp_ready = 2'b00;
                bp_cnt = 0;
            end
        end
    end

    // Present a request and wait for its accept; returns the model's predicted winner.
    task automatic issue(input logic [1:0] vld, input logic [3:0] a0, input logic [3:0] b0,
                         input logic [3:0] a1, input logic [3:0] b1, input int lat, output bit w);
        bit got;
`ifdef MULT_ARB_FIXED_PRIO_EN
        w = (vld == 2'b10);
`else
        w = (vld == 2'b11) ? ~model_last : (vld == 2'b10);
`endif
        exp_a = w ? a1 : a0;
        exp_b = w ? b1 : b0;
        cur_lat = lat;
        bus.req_a0 = a0;
        bus.req_b0 = b0;
        bus.req_a1 = a1;
        bus.req_b1 = b1;
        bus.req_valid = vld;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                got = 1'b1;
                acc_cyc = cyc;
                chk("req_ready_winner", bus.req_ready, w ? 2'b10 : 2'b01);
            end
        end
        if (!got) chk("accept_timeout", bus.req_ready, w ? 2'b10 : 2'b01);
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic [1:0] vld, input logic [3:0] a0, input logic [3:0] b0,
                          input logic [3:0] a1, input logic [3:0] b1, input int lat, input int bp);
        bit   w;
        exp_t ex;
        cur_bp = bp;
        issue(vld, a0, b0, a1, b1, lat, w);
        ex.owner = w;
        ex.err   = (lat == 0);
        ex.prod  = ex.err ? 8'd0 : ({4'd0, exp_a} * {4'd0, exp_b});
        exp_q.push_back(ex);
        // keep requesters and operands busy while the transaction is in flight
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            bus.req_valid = 2'($urandom);
            bus.req_a0 = 4'($urandom);
            bus.req_b0 = 4'($urandom);
            bus.req_a1 = 4'($urandom);
            bus.req_b1 = 4'($urandom);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 2'b00;
        if (exp_q.size() != 0) begin
            chk("response_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        bit w;
        rst = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_a0 = 4'd0;
        bus.req_b0 = 4'd0;
        bus.req_a1 = 4'd0;
        bus.req_b1 = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("no_accept_at_release", bus.req_ready, 2'b00);
        @(posedge clk);
        #1 bus.req_valid = 2'b00;

        do_txn(2'b11, 4'd2, 4'd3, 4'd4, 4'd5, 3, 0);
        do_txn(2'b11, 4'd6, 4'd7, 4'd8, 4'd9, 2, 1);
        do_txn(2'b01, 4'd3, 4'd5, 4'd0, 4'd0, 4, 0);
        do_txn(2'b10, 4'd1, 4'd1, 4'd9, 4'd9, 0, 0);
        do_txn(2'b11, 4'd15, 4'd15, 4'd2, 4'd2, 5, 5);
        do_txn(2'b10, 4'd4, 4'd4, 4'd11, 4'd13, TIMEOUT, 1);

        // reset while the multiplier is still running
        cur_bp = 0;
        issue(2'b10, 4'd0, 4'd0, 4'd7, 4'd9, 0, w);
        bus.req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("midwait");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        in_rsp = 1'b0;
        nstart = 0;
        model_last = 1'b1;
        late_pulse = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("late_done_rsp_valid", bus.rsp_valid, 2'b00);
            chk("late_done_busy", busy, 1'b0);
        end
        @(posedge clk);
        #1;
        do_txn(2'b11, 4'd5, 4'd6, 4'd7, 4'd8, 2, 0);

        for (int t = 0; t < 30; t++) begin
            logic [1:0] v;
            int         lat;
            int         r;
            v = 2'($urandom_range(1, 3));
            r = $urandom_range(0, 9);
            lat = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 6);
            do_txn(v, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), lat, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
